vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ACC_CYCLES, default 2: memory access length in clk cycles, legal range 1..15.
REQ-002 Parameter MAX_VID_STREAK, default 2: maximum number of consecutive video grants while cpu_req is pending, legal range 1..7.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 vid_req  in  1  video fetch request, level; held until vid_ack.
REQ-006 vid_addr  in  24  video fetch address (video address generator output); stable while vid_req is high.
REQ-007 vid_ack  out  1  one-cycle pulse; fetch complete.
REQ-008 vid_data  out  8  last fetched video byte.
REQ-009 cpu_req  in  1  CPU access request, level; held until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-011 cpu_addr  in  24  CPU address; stable while cpu_req is high.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_ack  out  1  one-cycle pulse; CPU access complete.
REQ-014 cpu_rdata  out  8  last CPU read byte.
REQ-015 mem_addr  out  24  VRAM address.
REQ-016 mem_wdata  out  8  VRAM write data.
REQ-017 mem_oe  out  1  VRAM read strobe.
REQ-018 mem_we  out  1  VRAM write strobe.
REQ-019 mem_rdata  in  8  VRAM read data; valid by the last access cycle.

Function
REQ-020 The FSM SHALL have four states: IDLE, VID_ACC, CPU_ACC, DONE.
REQ-021 IDLE -> VID_ACC when vid_req=1 and (cpu_req=0 or streak<MAX_VID_STREAK).
REQ-022 IDLE -> CPU_ACC when the REQ-021 condition is false and cpu_req=1.
REQ-023 When both requests are high and streak>=MAX_VID_STREAK, the CPU SHALL be granted; this bounds CPU wait to MAX_VID_STREAK video accesses.
REQ-024 On a video grant, streak SHALL increment, saturating at MAX_VID_STREAK; on a CPU grant, streak SHALL clear to 0.
REQ-025 On grant, the arbiter SHALL register the address, write data and we of the winning requester into mem_addr/mem_wdata and an internal we flag.
REQ-026 The access state SHALL last exactly ACC_CYCLES cycles, counted by a 4-bit down-counter.
REQ-027 mem_oe SHALL be high for every cycle of VID_ACC, and of CPU_ACC when cpu_we=0.
REQ-028 mem_we SHALL be high for every cycle of CPU_ACC when cpu_we=1.
REQ-029 mem_oe and mem_we SHALL never be high simultaneously; both SHALL be low in IDLE and DONE.
REQ-030 On the last access cycle, mem_rdata SHALL be captured: into vid_data for VID_ACC, into cpu_rdata for a CPU read; a CPU write SHALL leave cpu_rdata unchanged.
REQ-031 The access state SHALL then go to DONE for one cycle, with the matching ack high; DONE -> IDLE unconditionally.
REQ-032 Requesters SHALL drop or renew req on the edge ending the ack cycle; a req still high in IDLE is a new request.
REQ-033 Latency from req rising in IDLE to ack SHALL be ACC_CYCLES+1 cycles; throughput SHALL be one access per ACC_CYCLES+2 cycles.
REQ-034 mem_addr and mem_wdata SHALL hold their values outside access states.
REQ-035 vid_data and cpu_rdata SHALL hold until their next capture.
REQ-036 Input changes during an access SHALL NOT affect the access in progress.

Reset
REQ-037 While rst_n=0, the FSM SHALL be in IDLE and the following SHALL be 0: streak, counter, vid_ack, cpu_ack, mem_oe, mem_we, mem_addr, mem_wdata, vid_data, cpu_rdata.
REQ-038 Reset asserted mid-access SHALL abort the access immediately, with no ack and no data capture.
REQ-039 Deassertion of rst_n SHALL be synchronised externally; the block starts in IDLE on the first clk edge after release.

Structure
REQ-040 The shared package vid_pkg SHALL hold: VRAM_AW=24, VRAM_DW=8, and the arbiter state enum.
REQ-041 The block SHALL be a single module with no sub-module; the streak counter and access counter are inline.

Verification
REQ-042 Single video fetch, ACC_CYCLES=2: vid_req with vid_addr=0x01C123 and mem_rdata=0x5A -> mem_oe high for 2 cycles at 0x01C123; vid_ack 3 cycles after req; vid_data=0x5A.
REQ-043 CPU write: cpu_we=1, cpu_addr=0x004000, cpu_wdata=0xA5 -> mem_we high for 2 cycles, mem_oe low, cpu_ack pulse, cpu_rdata unchanged.
REQ-044 Starvation bound, MAX_VID_STREAK=2: vid_req and cpu_req held continuously -> grant order V,V,C,V,V,C.
REQ-045 Reset mid-access: rst_n low during the 2nd CPU_ACC cycle -> mem_we=0 at once, no cpu_ack, state IDLE after release.
REQ-046 Simultaneous requests with streak=0 -> video granted first; CPU acked ACC_CYCLES+2 cycles after vid_ack.
REQ-047 Assertion over all scenarios: mem_oe and mem_we are never both high, and each ack pulses exactly once per grant.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared VRAM definitions: bus widths and the arbiter state encoding.
package vid_pkg;

   localparam int unsigned VRAM_AW = 24;
   localparam int unsigned VRAM_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      VID_ACC,
      CPU_ACC,
      DONE
   } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: video has priority, bounded by a streak limit so
// a pending CPU access waits for at most MAX_VID_STREAK video fetches.
module vram_arbiter
   import vid_pkg::*;
#(
   parameter int unsigned ACC_CYCLES     = 2,
   parameter int unsigned MAX_VID_STREAK = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vid_req,
   input  logic [VRAM_AW-1:0] vid_addr,
   output logic               vid_ack,
   output logic [VRAM_DW-1:0] vid_data,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [VRAM_AW-1:0] cpu_addr,
   input  logic [VRAM_DW-1:0] cpu_wdata,
   output logic               cpu_ack,
   output logic [VRAM_DW-1:0] cpu_rdata,
   output logic [VRAM_AW-1:0] mem_addr,
   output logic [VRAM_DW-1:0] mem_wdata,
   output logic               mem_oe,
   output logic               mem_we,
   input  logic [VRAM_DW-1:0] mem_rdata
);

   localparam logic [3:0] ACC_LOAD   = 4'(ACC_CYCLES);
   localparam logic [2:0] STREAK_MAX = 3'(MAX_VID_STREAK);

   arb_state_e         state_q, state_d;
   logic [2:0]         streak_q, streak_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic               vid_ack_q, vid_ack_d;
   logic               cpu_ack_q, cpu_ack_d;
   logic [VRAM_AW-1:0] addr_q, addr_d;
   logic [VRAM_DW-1:0] wdata_q, wdata_d;
   logic [VRAM_DW-1:0] vdata_q, vdata_d;
   logic [VRAM_DW-1:0] cdata_q, cdata_d;
   logic               vid_win, cpu_win, last_cyc;

   assign vid_win  = vid_req && (!cpu_req || (streak_q < STREAK_MAX));
   assign cpu_win  = !vid_win && cpu_req;
   assign last_cyc = (cnt_q == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (vid_win)      state_d = VID_ACC;
            else if (cpu_win) state_d = CPU_ACC;
         end
         VID_ACC, CPU_ACC: if (last_cyc) state_d = DONE;
         DONE:             state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_oe = (state_q == VID_ACC) || ((state_q == CPU_ACC) && !we_q);
      mem_we = (state_q == CPU_ACC) && we_q;
   end

   // Grant registers the winner's request; acks are raised on the last access
   // cycle so they appear exactly during DONE.
   always_comb begin
      streak_d  = streak_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      vdata_d   = vdata_q;
      cdata_d   = cdata_q;
      vid_ack_d = 1'b0;
      cpu_ack_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (vid_win) begin
               streak_d = (streak_q < STREAK_MAX) ? streak_q + 3'd1 : STREAK_MAX;
               cnt_d    = ACC_LOAD;
               we_d     = 1'b0;
               addr_d   = vid_addr;
            end else if (cpu_win) begin
               streak_d = '0;
               cnt_d    = ACC_LOAD;
               we_d     = cpu_we;
               addr_d   = cpu_addr;
               wdata_d  = cpu_wdata;
            end
         end
         VID_ACC: begin
            cnt_d = cnt_q - 4'd1;
            if (last_cyc) begin
               vdata_d   = mem_rdata;
               vid_ack_d = 1'b1;
            end
         end
         CPU_ACC: begin
            cnt_d = cnt_q - 4'd1;
            if (last_cyc) begin
               if (!we_q) cdata_d = mem_rdata;
               cpu_ack_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q  <= '0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         vid_ack_q <= 1'b0;
         cpu_ack_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         vdata_q   <= '0;
         cdata_q   <= '0;
      end else begin
         streak_q  <= streak_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         vid_ack_q <= vid_ack_d;
         cpu_ack_q <= cpu_ack_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         vdata_q   <= vdata_d;
         cdata_q   <= cdata_d;
      end
   end

   assign vid_ack   = vid_ack_q;
   assign cpu_ack   = cpu_ack_q;
   assign vid_data  = vdata_q;
   assign cpu_rdata = cdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// request traffic, checked against a transaction-level arbitration model.
module tb_vram_arbiter;
   import vid_pkg::*;

   localparam int unsigned ACC  = 2;
   localparam int unsigned MAXS = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               vid_req = 1'b0;
   logic [VRAM_AW-1:0] vid_addr = '0;
   logic               vid_ack;
   logic [VRAM_DW-1:0] vid_data;
   logic               cpu_req = 1'b0;
   logic               cpu_we = 1'b0;
   logic [VRAM_AW-1:0] cpu_addr = '0;
   logic [VRAM_DW-1:0] cpu_wdata = '0;
   logic               cpu_ack;
   logic [VRAM_DW-1:0] cpu_rdata;
   logic [VRAM_AW-1:0] mem_addr;
   logic [VRAM_DW-1:0] mem_wdata;
   logic               mem_oe;
   logic               mem_we;
   logic [VRAM_DW-1:0] mem_rdata = '0;

   vram_arbiter #(.ACC_CYCLES(ACC), .MAX_VID_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned ack_cyc = 0;

   // Reference model state
   int unsigned        m_streak = 0;
   logic [VRAM_AW-1:0] m_addr = '0;
   logic [VRAM_DW-1:0] m_wdata = '0;
   logic [VRAM_DW-1:0] m_vdata = '0;
   logic [VRAM_DW-1:0] m_cdata = '0;
   bit                 use_fixed = 1'b0;
   logic [VRAM_DW-1:0] fixed_rd = '0;
   bit                 perturb = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      m_streak = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_vdata  = '0;
      m_cdata  = '0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_oe"},    32'(mem_oe),    32'd0);
      chk({tag, "_we"},    32'(mem_we),    32'd0);
      chk({tag, "_vack"},  32'(vid_ack),   32'd0);
      chk({tag, "_cack"},  32'(cpu_ack),   32'd0);
      chk({tag, "_addr"},  32'(mem_addr),  32'(m_addr));
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'(m_wdata));
      chk({tag, "_vdata"}, 32'(vid_data),  32'(m_vdata));
      chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(m_cdata));
   endtask

   // Starts in an IDLE cycle with request levels already driven; returns the
   // grant seen on the DUT acks (0 none, 1 video, 2 cpu) and ends in IDLE.
   task automatic transact(output int obs_w);
      bit                 v_win, c_win, wr;
      logic [VRAM_DW-1:0] rd;
      obs_w = 0;
      rd    = '0;
      check_quiet("idle");
      v_win = vid_req && (!cpu_req || m_streak < MAXS);
      c_win = !v_win && cpu_req;
      if (!v_win && !c_win) begin
         tick();
         return;
      end
      if (v_win) begin
         m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
         m_addr   = vid_addr;
         wr       = 1'b0;
      end else begin
         m_streak = 0;
         m_addr   = cpu_addr;
         m_wdata  = cpu_wdata;
         wr       = cpu_we;
      end
      for (int k = 1; k <= int'(ACC); k++) begin
         tick();
         rd = use_fixed ? fixed_rd : 8'($urandom);
         mem_rdata = rd;
         if (perturb) cpu_wdata = 8'($urandom);
         chk("acc_oe",    32'(mem_oe),    32'(!wr));
         chk("acc_we",    32'(mem_we),    32'(wr));
         chk("acc_addr",  32'(mem_addr),  32'(m_addr));
         chk("acc_wdata", 32'(mem_wdata), 32'(m_wdata));
         chk("acc_vack",  32'(vid_ack),   32'd0);
         chk("acc_cack",  32'(cpu_ack),   32'd0);
      end
      if (v_win)   m_vdata = rd;
      else if (!wr) m_cdata = rd;
      tick();
      chk("done_vack",  32'(vid_ack),   32'(v_win));
      chk("done_cack",  32'(cpu_ack),   32'(c_win));
      chk("done_oe",    32'(mem_oe),    32'd0);
      chk("done_we",    32'(mem_we),    32'd0);
      chk("done_addr",  32'(mem_addr),  32'(m_addr));
      chk("done_vdata", 32'(vid_data),  32'(m_vdata));
      chk("done_rdata", 32'(cpu_rdata), 32'(m_cdata));
      if (vid_ack)      obs_w = 1;
      else if (cpu_ack) obs_w = 2;
      ack_cyc = cyc;
      tick();
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         assert ((mem_oe && mem_we) === 1'b0) else begin
            errors++;
            $error("FAIL strobe_excl observed=%b%b expected=not both high", mem_oe, mem_we);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int order[6];
      int unsigned t_v;
      logic [VRAM_DW-1:0] rd_before;
      order = '{1, 1, 2, 1, 1, 2};

      // Reset values
      tick();
      tick();
      check_quiet("reset");
      rst_n = 1'b1;
      tick();
      check_quiet("post_reset");

      // Single video fetch
      vid_addr  = 24'h01C123;
      vid_req   = 1'b1;
      use_fixed = 1'b1;
      fixed_rd  = 8'h5A;
      transact(w);
      vid_req = 1'b0;
      chk("vid_grant", 32'(w), 32'd1);
      chk("vid_data_5a", 32'(vid_data), 32'h5A);
      use_fixed = 1'b0;

      // CPU write leaves cpu_rdata untouched
      rd_before = cpu_rdata;
      cpu_we    = 1'b1;
      cpu_addr  = 24'h004000;
      cpu_wdata = 8'hA5;
      cpu_req   = 1'b1;
      transact(w);
      cpu_req = 1'b0;
      chk("cpu_wr_grant", 32'(w), 32'd2);
      chk("cpu_wr_rdata_hold", 32'(cpu_rdata), 32'(rd_before));
      chk("cpu_wr_wdata", 32'(mem_wdata), 32'hA5);

      // Starvation bound: both held continuously
      cpu_we   = 1'b0;
      vid_addr = 24'h000100;
      cpu_addr = 24'h00F000;
      vid_req  = 1'b1;
      cpu_req  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         transact(w);
         chk($sformatf("order_%0d", i), 32'(w), 32'(order[i]));
      end

      // Simultaneous requests from streak 0: video first, CPU ACC+2 later
      transact(w);
      chk("simul_first", 32'(w), 32'd1);
      t_v = ack_cyc;
      vid_req = 1'b0;
      transact(w);
      cpu_req = 1'b0;
      chk("simul_second", 32'(w), 32'd2);
      chk("simul_latency", 32'(ack_cyc - t_v), 32'(ACC + 2));

      // Reset during second CPU_ACC cycle aborts without ack
      cpu_we    = 1'b1;
      cpu_addr  = 24'h123456;
      cpu_wdata = 8'h3C;
      cpu_req   = 1'b1;
      check_quiet("abort_idle");
      tick();
      tick();
      chk("abort_we_before", 32'(mem_we), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_quiet("abort_now");
      tick();
      check_quiet("abort_held");
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      rst_n   = 1'b1;
      tick();
      check_quiet("abort_release");

      // Random traffic
      perturb = 1'b1;
      for (int n = 0; n < 80; n++) begin
         transact(w);
         if (w == 1 || !vid_req) begin
            vid_req  = ($urandom_range(0, 3) != 0);
            vid_addr = 24'($urandom);
         end
         if (w == 2 || !cpu_req) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom);
            cpu_addr  = 24'($urandom);
            cpu_wdata = 8'($urandom);
         end
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;
      transact(w);
      check_quiet("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
